bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 32, binary operand width (>=1).
REQ-002 Parameter DIGITS, default 10, number of BCD output digits (>=1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request conversion of bin_in; accepted only when ready=1.
REQ-006 bin_in  input  WIDTH  unsigned operand, sampled on the accepting edge only.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 valid  output  1  one-cycle pulse marking a new result.
REQ-009 bcd  output  4*DIGITS  result, digit k in bits [4k+3:4k], digit 0 = units.
REQ-010 sig_digits  output  $clog2(DIGITS+1)  count of significant digits, min 1.
REQ-011 overflow  output  1  high when the operand is >= 10^DIGITS.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; ready=1 only in IDLE.
REQ-013 On start=1 in IDLE, the block SHALL capture bin_in into a shift register, clear the scratch digits and overflow flag, load bit counter with WIDTH, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL add 3 to every scratch digit >=5, then shift all digits left one bit, moving the operand MSB into digit 0 and decrementing the counter.
REQ-015 A 1 shifted out of bit 3 of the top digit SHALL set a sticky overflow flag for the current conversion.
REQ-016 After the WIDTH-th shift, the FSM SHALL enter DONE, register bcd, sig_digits and overflow, assert valid for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: start accepted at edge N -> valid high in the cycle after edge N+WIDTH+1; throughput one result per WIDTH+2 cycles.
REQ-018 On overflow, bcd SHALL equal the operand modulo 10^DIGITS.
REQ-019 sig_digits SHALL equal one plus the index of the highest non-zero digit, and 1 for a zero result.
REQ-020 start while ready=0, including the DONE cycle, SHALL be ignored without effect on the conversion in flight.
REQ-021 bcd, sig_digits and overflow SHALL hold their last values until the next valid.
REQ-022 Changes on bin_in after the accepting edge SHALL not affect the result.

Reset
REQ-023 While reset=1, state SHALL be IDLE and valid, bcd, sig_digits and overflow 0, ready 1.
REQ-024 Reset during SHIFT or DONE SHALL abort the conversion with no valid pulse.
REQ-025 The first start after reset release SHALL be accepted on the first rising edge.

Structure
REQ-026 Package bcd_pkg SHALL hold the FSM state enum, a 4-bit BCD digit typedef, and an add-3 correction function.
REQ-027 Sub-module bcd_digit_cell, one 4-bit digit with add-3 and shift-in/shift-out, SHALL be instantiated DIGITS times by a generate loop.

Verification
REQ-028 WIDTH=32, DIGITS=10, bin_in=32'hFFFFFFFF -> valid 34 cycles after start edge, bcd=4294967295, sig_digits=10, overflow=0.
REQ-029 bin_in=0 -> bcd=0, sig_digits=1, overflow=0.
REQ-030 WIDTH=16, DIGITS=3, bin_in=1234 -> bcd=234, sig_digits=3, overflow=1.
REQ-031 start pulsed at cycles 5 and 20 of a conversion -> ignored, one valid; start on the cycle ready returns to 1 -> accepted, back-to-back results correct.
REQ-032 reset asserted at SHIFT cycle 10 -> no valid, outputs 0, ready=1; next start of 1000000000 -> bcd=1000000000, sig_digits=10.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit type and the double-dabble correction.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // A digit of 5 or more would exceed 9 after doubling, so pre-bias it by 3.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_cell.sv
// One BCD scratch digit of the double-dabble chain: add-3 correction, then shift
// left one bit, taking shift_in at the bottom and passing the corrected bit 3 upward.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       shift_in,
  output logic       shift_out,
  output bcd_digit_t digit
);

  bcd_digit_t corrected;

  assign corrected = add3(digit);
  assign shift_out = corrected[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (shift_en) begin
      digit <= {corrected[2:0], shift_in};
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, WIDTH steps
// per conversion, result registered in DONE with a single-cycle valid pulse.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin_in,
  output logic                         ready,
  output logic                         valid,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  sig_digits,
  output logic                         overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(DIGITS + 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]          state;
  logic [WIDTH-1:0]    operand;
  logic [CW-1:0]       count;
  logic                ovf_sticky;
  logic                load;
  logic                shift_en;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] scratch;
  logic [SW-1:0]       sig_next;

  assign ready    = (state == IDLE);
  assign load     = (state == IDLE) && start;
  assign shift_en = (state == SHIFT);
  assign carry[0] = operand[WIDTH-1];

  // The carry chain runs units -> top digit; whatever leaves the top digit is overflow.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .clear     (load),
      .shift_en  (shift_en),
      .shift_in  (carry[g]),
      .shift_out (carry[g+1]),
      .digit     (scratch[4*g +: 4])
    );
  end

  always_comb begin
    sig_next = SW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] != 4'd0) begin
        sig_next = SW'(k + 1);
      end
    end
  end

  // Outputs only change on the DONE->IDLE edge so they hold between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      operand    <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      valid      <= 1'b0;
      bcd        <= '0;
      sig_digits <= '0;
      overflow   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand    <= bin_in;
            count      <= CW'(WIDTH);
            ovf_sticky <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          operand <= operand << 1;
          count   <= count - CW'(1);
          if (carry[DIGITS]) begin
            ovf_sticky <= 1'b1;
          end
          if (count == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd        <= scratch;
          sig_digits <= sig_next;
          overflow   <= ovf_sticky;
          valid      <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 32-bit/10-digit instance and a
// 16-bit/3-digit instance compared against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic [31:0] bin32 = '0;
  logic        ready32, valid32, ovf32;
  logic [39:0] bcd32;
  logic [3:0]  sig32;

  logic        start16 = 1'b0;
  logic [15:0] bin16 = '0;
  logic        ready16, valid16, ovf16;
  logic [11:0] bcd16;
  logic [1:0]  sig16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .bin_in(bin32),
    .ready(ready32), .valid(valid32), .bcd(bcd32), .sig_digits(sig32), .overflow(ovf32)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(3)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .bin_in(bin16),
    .ready(ready16), .valid(valid16), .bcd(bcd16), .sig_digits(sig16), .overflow(ovf16)
  );

  // Decimal reference: value modulo 10^nd split into digits by repeated division.
  function automatic void ref_model(input longint unsigned v, input int nd,
                                    output logic [39:0] b, output int sig, output logic ovf);
    longint unsigned p = 1;
    longint unsigned r;
    b = '0;
    for (int k = 0; k < nd; k++) p = p * 10;
    ovf = (v >= p);
    r = v % p;
    sig = 1;
    for (int k = 0; k < nd; k++) begin
      b[4*k +: 4] = 4'(r % 10);
      if ((r % 10) != 0) sig = k + 1;
      r = r / 10;
    end
  endfunction

  // Starts a conversion from a negedge and returns the negedge index of valid (-1 on timeout).
  task automatic run32(input logic [31:0] v, output int lat);
    start32 = 1'b1;
    bin32   = v;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    bin32   = $urandom;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) @(negedge clk);
      if (valid32) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run16(input logic [15:0] v, output int lat);
    start16 = 1'b1;
    bin16   = v;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    bin16   = 16'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (valid16) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ready32, valid32, bcd32, sig32, ovf32} !== {1'b1, 1'b0, 40'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset32: got ready=%b valid=%b bcd=%h sig=%0d ovf=%b, want 1 0 0 0 0",
               ready32, valid32, bcd32, sig32, ovf32);
    end
    checks++;
    if ({ready16, valid16, bcd16, sig16, ovf16} !== {1'b1, 1'b0, 12'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset16: got ready=%b valid=%b bcd=%h sig=%0d ovf=%b, want 1 0 0 0 0",
               ready16, valid16, bcd16, sig16, ovf16);
    end
    reset = 1'b0;
  endtask

  task automatic test_max;
    int lat;
    logic [39:0] eb;
    int es;
    logic eo;
    ref_model(64'hFFFFFFFF, 10, eb, es, eo);
    run32(32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("[TB] FAIL max_latency: got %0d want 34", lat);
    end
    checks++;
    if ({bcd32, sig32, ovf32} !== {40'h4294967295, 4'd10, 1'b0} ||
        {bcd32, sig32, ovf32} !== {eb, 4'(es), eo}) begin
      errors++;
      $display("[TB] FAIL max_result: got bcd=%h sig=%0d ovf=%b want 4294967295 10 0",
               bcd32, sig32, ovf32);
    end
    checks++;
    if (ready32 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL max_ready_at_valid: got %b want 1", ready32);
    end
    @(negedge clk);
    checks++;
    if ({valid32, bcd32, sig32} !== {1'b0, 40'h4294967295, 4'd10}) begin
      errors++;
      $display("[TB] FAIL max_hold: got valid=%b bcd=%h sig=%0d want 0 4294967295 10",
               valid32, bcd32, sig32);
    end
  endtask

  task automatic test_zero;
    int lat;
    run32(32'd0, lat);
    checks++;
    if (lat !== 34 || {bcd32, sig32, ovf32} !== {40'd0, 4'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL zero: got lat=%0d bcd=%h sig=%0d ovf=%b want 34 0 1 0",
               lat, bcd32, sig32, ovf32);
    end
  endtask

  task automatic test_overflow16;
    int lat;
    run16(16'd1234, lat);
    checks++;
    if (lat !== 18 || {bcd16, sig16, ovf16} !== {12'h234, 2'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovf16: got lat=%0d bcd=%h sig=%0d ovf=%b want 18 234 3 1",
               lat, bcd16, sig16, ovf16);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [39:0] eb;
    int es;
    logic eo;
    logic [31:0] v;
    logic [15:0] w;
    for (int n = 0; n < 8; n++) begin
      v = (n % 2 == 0) ? $urandom : ($urandom % 1000);
      ref_model(longint'(v), 10, eb, es, eo);
      run32(v, lat);
      checks++;
      if (lat !== 34 || {bcd32, sig32, ovf32} !== {eb, 4'(es), eo}) begin
        errors++;
        $display("[TB] FAIL rand32 v=%0d: got lat=%0d bcd=%h sig=%0d ovf=%b want 34 %h %0d %b",
                 v, lat, bcd32, sig32, ovf32, eb, es, eo);
      end
    end
    for (int n = 0; n < 8; n++) begin
      w = (n % 2 == 0) ? 16'($urandom) : 16'($urandom % 1000);
      ref_model(longint'(w), 3, eb, es, eo);
      run16(w, lat);
      checks++;
      if (lat !== 18 || {bcd16, sig16, ovf16} !== {eb[11:0], 2'(es), eo}) begin
        errors++;
        $display("[TB] FAIL rand16 v=%0d: got lat=%0d bcd=%h sig=%0d ovf=%b want 18 %h %0d %b",
                 w, lat, bcd16, sig16, ovf16, eb[11:0], es, eo);
      end
    end
  endtask

  // Starts during busy cycles (including DONE) are ignored; start as ready returns is taken.
  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic [39:0] ea, eb;
    int es_a, es_b;
    logic eo_a, eo_b;
    int nvalid;
    int lat;
    a = $urandom;
    b = $urandom;
    ref_model(longint'(a), 10, ea, es_a, eo_a);
    ref_model(longint'(b), 10, eb, es_b, eo_b);
    start32 = 1'b1;
    bin32   = a;
    @(posedge clk);
    nvalid = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (valid32) nvalid++;
      if (i == 5 || i == 20 || i == 33) begin
        start32 = 1'b1;
        bin32   = $urandom;
      end else begin
        start32 = 1'b0;
        bin32   = $urandom;
      end
    end
    checks++;
    if (nvalid !== 1 || valid32 !== 1'b1 || {bcd32, sig32, ovf32} !== {ea, 4'(es_a), eo_a}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got nvalid=%0d valid=%b bcd=%h sig=%0d want 1 1 %h %0d",
               nvalid, valid32, bcd32, sig32, ea, es_a);
    end
    start32 = 1'b1;
    bin32   = b;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    bin32   = $urandom;
    checks++;
    if (ready32 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got ready=%b want 0", ready32);
    end
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) @(negedge clk);
      if (valid32) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 34 || {bcd32, sig32, ovf32} !== {eb, 4'(es_b), eo_b}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d bcd=%h sig=%0d want 34 %h %0d",
               lat, bcd32, sig32, eb, es_b);
    end
  endtask

  task automatic test_reset_abort;
    int nvalid;
    int lat;
    start32 = 1'b1;
    bin32   = $urandom;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start32 = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ready32, valid32, bcd32, sig32, ovf32} !== {1'b1, 1'b0, 40'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL abort_reset: got ready=%b valid=%b bcd=%h sig=%0d ovf=%b want 1 0 0 0 0",
               ready32, valid32, bcd32, sig32, ovf32);
    end
    @(negedge clk);
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid32) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d pulses want 0", nvalid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run32(32'd1000000000, lat);
    checks++;
    if (lat !== 34 || {bcd32, sig32, ovf32} !== {40'h1000000000, 4'd10, 1'b0}) begin
      errors++;
      $display("[TB] FAIL abort_restart: got lat=%0d bcd=%h sig=%0d ovf=%b want 34 1000000000 10 0",
               lat, bcd32, sig32, ovf32);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_max();
    test_zero();
    test_overflow16();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
